// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the debouncer array.
package debouncer_pkg;

    typedef enum logic {STABLE, SETTLING} deb_state_t;

    localparam int unsigned GLITCH_W = 8;

    function automatic int unsigned cnt_width(input int unsigned ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debouncer channel: synchroniser, settle FSM with counter, edge pulses.
// Optional glitch counter when DEBOUNCER_ARRAY_GLITCH_CNT_EN is defined.
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int unsigned TICKS       = 10000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_raw,
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
    input  logic                i_glitch_clr,
    output logic [GLITCH_W-1:0] o_glitch_cnt,
`endif
    output logic                o_level,
    output logic                o_rise,
    output logic                o_fall
);

    localparam int unsigned    CW      = cnt_width(TICKS);
    localparam logic [CW-1:0] CntLast = CW'(TICKS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    deb_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    deb_state_t             w_state_d;
    logic [CW-1:0]          w_cnt_d;
    logic                   w_level_d;
    logic                   w_rise_d;
    logic                   w_fall_d;
    logic                   w_accept;
    logic                   w_abort;
    logic                   w_s;

    // Synchroniser flops load RESET_VAL so reset release never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = '0;
        w_level_d = r_level;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        w_accept  = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            STABLE: begin
                if (w_s != r_level) begin
                    if (TICKS == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_d = SETTLING;
                        w_cnt_d   = CW'(1);
                    end
                end
            end
            SETTLING: begin
                if (w_s == r_level) begin
                    w_state_d = STABLE;
                    w_abort   = 1'b1;
                end else if (r_cnt == CntLast) begin
                    w_accept = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
        endcase
        if (w_accept) begin
            w_state_d = STABLE;
            w_cnt_d   = '0;
            w_level_d = w_s;
            w_rise_d  = w_s;
            w_fall_d  = ~w_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_level <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch;

    // Clear has priority over a same-cycle abort.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_glitch_clr) begin
            r_glitch <= '0;
        end else if (w_abort && (r_glitch != {GLITCH_W{1'b1}})) begin
            r_glitch <= r_glitch + 1'b1;
        end
    end

    assign o_glitch_cnt = r_glitch;
`else
    logic w_unused_abort;
    assign w_unused_abort = w_abort;
`endif

endmodule

// File: rtl/debouncer_array.sv
// Multi-channel debouncer top: one debouncer_channel per input plus a shared change flag.
// Define DEBOUNCER_ARRAY_GLITCH_CNT_EN to add per-channel glitch counters.
module debouncer_array
    import debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned TICKS       = 10000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          i,
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
    input  logic                         glitch_clr,
    output logic [CHANNELS*GLITCH_W-1:0] glitch_cnt,
`endif
    output logic [CHANNELS-1:0]          o,
    output logic [CHANNELS-1:0]          rise,
    output logic [CHANNELS-1:0]          fall,
    output logic                         changed
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        debouncer_channel #(
            .TICKS       (TICKS),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL)
        ) u_channel (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_raw        (i[k]),
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
            .i_glitch_clr (glitch_clr),
            .o_glitch_cnt (glitch_cnt[k*GLITCH_W +: GLITCH_W]),
`endif
            .o_level      (o[k]),
            .o_rise       (rise[k]),
            .o_fall       (fall[k])
        );
    end

    assign changed = |(rise | fall);

endmodule

// File: tb/tb_debouncer_array.sv
// Scoreboard bench for debouncer_array (CHANNELS=4, TICKS=16, SYNC_STAGES=2, RESET_VAL=0).
module tb_debouncer_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i   = 4'hF;
    logic [3:0]  o, rise, fall;
    logic        changed;
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
    logic        glitch_clr = 1'b0;
    logic [31:0] glitch_cnt;
`endif

    debouncer_array #(
        .CHANNELS    (4),
        .TICKS       (16),
        .SYNC_STAGES (2),
        .RESET_VAL   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i          (i),
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt),
`endif
        .o          (o),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] o;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    ev_t        q[$];
    ev_t        mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_o   = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Expected edge event d cycles after the current cycle.
    task automatic push(input int d, input logic [3:0] eo, input logic [3:0] er,
                        input logic [3:0] ef);
        ev_t e;
        e.cyc  = cyc + d;
        e.o    = eo;
        e.rise = er;
        e.fall = ef;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the next queued event; between pulses o must hold.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if ((changed | (|rise) | (|fall)) !== 1'b0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event at cycle %0d: o=%0h rise=%0h fall=%0h",
                             cyc, o, rise, fall);
                end else begin
                    mon_e = q.pop_front();
                    check("ev_cycle", cyc, mon_e.cyc);
                    check("ev_o", {28'd0, o}, {28'd0, mon_e.o});
                    check("ev_rise", {28'd0, rise}, {28'd0, mon_e.rise});
                    check("ev_fall", {28'd0, fall}, {28'd0, mon_e.fall});
                    check("ev_changed", {31'd0, changed}, 32'd1);
                    m_o = mon_e.o;
                end
            end else begin
                check("level_o", {28'd0, o}, {28'd0, m_o});
            end
        end
    end

    initial begin
        // 1. reset held with all inputs high
        repeat (5) begin
            @(negedge clk);
            check("rst_o", {28'd0, o}, 32'd0);
            check("rst_pulses", {24'd0, rise, fall}, 32'd0);
            check("rst_changed", {31'd0, changed}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(18, 4'hF, 4'hF, 4'h0);
        step(30);
        i = 4'h0;
        push(18, 4'h0, 4'h0, 4'hF);
        step(30);

        // 2. ch0 rise held 40 cycles
        i = 4'h1;
        push(18, 4'h1, 4'h1, 4'h0);
        step(40);
        i = 4'h0;
        push(18, 4'h0, 4'h0, 4'h1);
        step(30);

        // 3. ch1 bounce: 10 high, 3 low, then high
        i = 4'h2;
        step(10);
        i = 4'h0;
        step(3);
        i = 4'h2;
        push(18, 4'h2, 4'h2, 4'h0);
        step(30);
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
        check("glitch_ch1_bounce", {24'd0, glitch_cnt[15:8]}, 32'd1);
        check("glitch_ch0_bounce", {24'd0, glitch_cnt[7:0]}, 32'd0);
`endif
        i = 4'h0;
        push(18, 4'h0, 4'h0, 4'h2);
        step(30);

        // 4. ch2: 15-cycle pulse rejected, 16-cycle pulse accepted
        i = 4'h4;
        step(15);
        i = 4'h0;
        step(30);
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
        check("glitch_ch2_15", {24'd0, glitch_cnt[23:16]}, 32'd1);
`endif
        i = 4'h4;
        push(18, 4'h4, 4'h4, 4'h0);
        push(34, 4'h0, 4'h0, 4'h4);
        step(16);
        i = 4'h0;
        step(40);

        // 5. ch0 and ch3 together
        i = 4'h9;
        push(18, 4'h9, 4'h9, 4'h0);
        step(30);
        i = 4'h0;
        push(18, 4'h0, 4'h0, 4'h9);
        step(30);

        // 6. reset when ch1 count reaches 10, then count restarts from zero
        i = 4'h2;
        step(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push(18, 4'h2, 4'h2, 4'h0);
        step(5);
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
        check("glitch_after_rst", glitch_cnt, 32'd0);
`endif
        step(25);
        // reset after acceptance drops o silently
        rst = 1'b1;
        step(1);
        m_o = 4'h0;
        rst = 1'b0;
        push(18, 4'h2, 4'h2, 4'h0);
        step(30);
        i = 4'h0;
        push(18, 4'h0, 4'h0, 4'h2);
        step(30);

        // 300 aborts on ch3 saturate its glitch counter
        repeat (300) begin
            i = 4'h8;
            step(2);
            i = 4'h0;
            step(2);
        end
        step(10);
`ifdef DEBOUNCER_ARRAY_GLITCH_CNT_EN
        check("glitch_ch3_sat", {24'd0, glitch_cnt[31:24]}, 32'd255);
        check("glitch_others", {8'd0, glitch_cnt[23:0]}, 32'd0);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        check("glitch_clr", glitch_cnt, 32'd0);
`endif
        step(5);
        check("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
